// File: rtl/ap_mon_pkg.sv
// Shared types for the ap_ctrl channel monitor: channel FSM states,
// per-channel statistics record and the readout-select width helper.
package ap_mon_pkg;

  // Widest legal counter; instances with narrower counters zero-extend into it.
  localparam int STAT_W = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    DONE_WAIT = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [STAT_W-1:0] start_cnt;
    logic [STAT_W-1:0] done_cnt;
    logic [STAT_W-1:0] last_lat;
    logic [STAT_W-1:0] max_lat;
  } ch_stats_t;

  // Readout index width, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ap_channel_monitor_if.sv
// Bundle of per-channel ap_ctrl handshake lines observed by the monitor.
interface ap_channel_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;

  modport master (output ap_start, ap_ready, ap_done, ap_continue);
  modport slave  (input  ap_start, ap_ready, ap_done, ap_continue);
endinterface

// File: rtl/ap_channel_tracker.sv
// One ap_ctrl channel: transaction FSM, latency measurement and
// saturating statistics counters with a sticky overflow flag.
module ap_channel_tracker
  import ap_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      hold,
  input  logic      ap_start,
  input  logic      ap_ready,
  input  logic      ap_done,
  input  logic      ap_continue,
  output ch_stats_t stats,
  output ch_state_e state,
  output logic      overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] start_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] last_lat;
  logic [CNT_W-1:0] max_lat;
  logic             done_evt;
  logic [CNT_W-1:0] done_lat;

  // Detect a completing transaction and the latency it reports.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
    done_evt = 1'b0;
    done_lat = '0;
    case (state)
      IDLE: if (ap_start && ap_done) done_evt = 1'b1;
      RUN: begin
        done_evt = ap_done;
        done_lat = lat_cnt;
      end
      default: ;
    endcase
  end

  // Channel FSM plus counters; everything holds while the monitor is frozen.
  // NOTE: the reset term sits in the sensitivity list, so reset acts immediately without waiting for a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
      state     <= IDLE;
      start_cnt <= '0;
      done_cnt  <= '0;
      lat_cnt   <= '0;
      last_lat  <= '0;
      max_lat   <= '0;
      overflow  <= 1'b0;
    end else if (!hold) begin
      // Accepted starts count in any state, including pipelined re-starts.
      if (ap_start && ap_ready) begin
        if (start_cnt == CNT_MAX) overflow  <= 1'b1;
        else                      start_cnt <= start_cnt + CNT_W'(1);
      end

      if (done_evt) begin
        last_lat <= done_lat;
        if (done_lat > max_lat) max_lat <= done_lat;
        if (done_cnt == CNT_MAX) overflow <= 1'b1;
        else                     done_cnt <= done_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (ap_start && ap_done) begin
            state <= ap_continue ? IDLE : DONE_WAIT;
          end else if (ap_start) begin
            state   <= RUN;
            lat_cnt <= CNT_W'(1);
          end
        end
        RUN: begin
          if (ap_done)                state    <= ap_continue ? IDLE : DONE_WAIT;
          else if (lat_cnt == CNT_MAX) overflow <= 1'b1;
          else                        lat_cnt  <= lat_cnt + CNT_W'(1);
        end
        DONE_WAIT: if (ap_continue) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign stats.start_cnt = STAT_W'(start_cnt);
  assign stats.done_cnt  = STAT_W'(done_cnt);
  assign stats.last_lat  = STAT_W'(last_lat);
  assign stats.max_lat   = STAT_W'(max_lat);

endmodule

// File: rtl/ap_channel_monitor.sv
// Multi-channel ap_ctrl monitor: one tracker per channel, an end-of-test
// freeze and a registered readout mux selected by rd_sel.
module ap_channel_monitor
  import ap_mon_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 32,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                 clock,
  input  logic                 reset,
  ap_channel_monitor_if.slave  ctrl,
  input  logic                 finish,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_W-1:0]     rd_start_cnt,
  output logic [CNT_W-1:0]     rd_done_cnt,
  output logic [CNT_W-1:0]     rd_last_lat,
  output logic [CNT_W-1:0]     rd_max_lat,
  output logic [1:0]           rd_state,
  output logic                 frozen,
  output logic [NUM_CH-1:0]    overflow
);

  ch_stats_t stats [NUM_CH];
  ch_state_e ch_st [NUM_CH];
  ch_stats_t rd_next;
  ch_state_e rd_state_next;
  logic      unused_rd;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ap_channel_tracker #(.CNT_W(CNT_W)) u_tracker (
      .clock       (clock),
      .reset       (reset),
      .hold        (frozen),
      .ap_start    (ctrl.ap_start[g]),
      .ap_ready    (ctrl.ap_ready[g]),
      .ap_done     (ctrl.ap_done[g]),
      .ap_continue (ctrl.ap_continue[g]),
      .stats       (stats[g]),
      .state       (ch_st[g]),
      .overflow    (overflow[g])
    );
  end

  // Sticky freeze: once finish is seen, statistics stop until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  // Select the addressed channel; out-of-range indices read as zero.
  always_comb begin
    rd_next       = '0;
    rd_state_next = IDLE;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_next       = stats[i];
        rd_state_next = ch_st[i];
      end
    end
  end

  // Upper record bits beyond CNT_W are always zero.
  assign unused_rd = ^rd_next;

  // Registered readout, one cycle behind rd_sel; keeps working while frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_start_cnt <= '0;
      rd_done_cnt  <= '0;
      rd_last_lat  <= '0;
      rd_max_lat   <= '0;
      rd_state     <= IDLE;
    end else begin
      rd_start_cnt <= rd_next.start_cnt[CNT_W-1:0];
      rd_done_cnt  <= rd_next.done_cnt[CNT_W-1:0];
      rd_last_lat  <= rd_next.last_lat[CNT_W-1:0];
      rd_max_lat   <= rd_next.max_lat[CNT_W-1:0];
      rd_state     <= rd_state_next;
    end
  end

endmodule

// File: tb/tb_ap_channel_monitor.sv
// Directed bench for ap_channel_monitor (5 channels, 8-bit counters).
module tb_ap_channel_monitor;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int SW  = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic           finish;
  logic [SW-1:0]  rd_sel;
  logic [CW-1:0]  rd_start_cnt, rd_done_cnt, rd_last_lat, rd_max_lat;
  logic [1:0]     rd_state;
  logic           frozen;
  logic [NCH-1:0] overflow;

  int n_total = 0;
  int n_pass  = 0;

  ap_channel_monitor_if #(.NUM_CH(NCH)) ctrl ();

  ap_channel_monitor #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl         (ctrl),
    .finish       (finish),
    .rd_sel       (rd_sel),
    .rd_start_cnt (rd_start_cnt),
    .rd_done_cnt  (rd_done_cnt),
    .rd_last_lat  (rd_last_lat),
    .rd_max_lat   (rd_max_lat),
    .rd_state     (rd_state),
    .frozen       (frozen),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_rd(input string tag, input logic [CW-1:0] s, input logic [CW-1:0] d,
                        input logic [CW-1:0] l, input logic [CW-1:0] m, input logic [1:0] st);
    check({tag, ".start_cnt"}, rd_start_cnt, s);
    check({tag, ".done_cnt"},  rd_done_cnt,  d);
    check({tag, ".last_lat"},  rd_last_lat,  l);
    check({tag, ".max_lat"},   rd_max_lat,   m);
    check({tag, ".state"},     CW'(rd_state), CW'(st));
  endtask

  // Drive one channel for exactly one rising edge; returns on the next falling edge.
  task automatic cyc(input int ch, input int s, input int r, input int d, input int c);
    ctrl.ap_start[ch]    = (s != 0);
    ctrl.ap_ready[ch]    = (r != 0);
    ctrl.ap_done[ch]     = (d != 0);
    ctrl.ap_continue[ch] = (c != 0);
    @(negedge clock);
  endtask

  initial begin
    reset            = 1'b1;
    finish           = 1'b0;
    rd_sel           = '0;
    ctrl.ap_start    = '0;
    ctrl.ap_ready    = '0;
    ctrl.ap_done     = '0;
    ctrl.ap_continue = '1;
    #1;
    chk_rd("reset", 8'd0, 8'd0, 8'd0, 8'd0, 2'd0);
    check("reset.frozen",   CW'(frozen),   8'd0);
    check("reset.overflow", CW'(overflow), 8'd0);
    @(negedge clock);
    reset = 1'b0;

    // Ch0: start at E0, done at E0+5 with continue high -> latency 5.
    rd_sel = 3'd0;
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("ch0.run_state", CW'(rd_state), 8'd1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk_rd("ch0", 8'd1, 8'd1, 8'd5, 8'd5, 2'd0);

    // Ch1: latency 3, continue held low for four done-wait cycles, start while waiting.
    rd_sel = 3'd1;
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    check("ch1.wait_a", CW'(rd_state), 8'd2);
    cyc(1, 1, 1, 0, 0);
    check("ch1.wait_b", CW'(rd_state), 8'd2);
    cyc(1, 0, 0, 0, 0);
    check("ch1.wait_c", CW'(rd_state), 8'd2);
    check("ch1.wait_start", rd_start_cnt, 8'd2);
    cyc(1, 0, 0, 0, 1);
    check("ch1.wait_d", CW'(rd_state), 8'd2);
    cyc(1, 0, 0, 0, 1);
    check("ch1.idle", CW'(rd_state), 8'd0);
    cyc(1, 0, 0, 0, 1);
    chk_rd("ch1", 8'd2, 8'd1, 8'd3, 8'd3, 2'd0);

    // Ch3: zero-latency transaction, then latencies 7 and 3.
    rd_sel = 3'd3;
    cyc(3, 1, 1, 1, 1);
    cyc(3, 0, 0, 0, 1);
    cyc(3, 0, 0, 0, 1);
    chk_rd("ch3.zero", 8'd1, 8'd1, 8'd0, 8'd0, 2'd0);
    cyc(3, 1, 1, 0, 1);
    repeat (6) cyc(3, 0, 0, 0, 1);
    cyc(3, 0, 0, 1, 1);
    cyc(3, 1, 1, 0, 1);
    repeat (2) cyc(3, 0, 0, 0, 1);
    cyc(3, 0, 0, 1, 1);
    cyc(3, 0, 0, 0, 1);
    cyc(3, 0, 0, 0, 1);
    chk_rd("ch3", 8'd3, 8'd3, 8'd3, 8'd7, 2'd0);
    check("pre_sat.overflow", CW'(overflow), 8'd0);

    // Ch2: 300 back-to-back handshakes saturate the 8-bit counters.
    rd_sel = 3'd2;
    repeat (300) cyc(2, 1, 1, 1, 1);
    cyc(2, 0, 0, 0, 1);
    cyc(2, 0, 0, 0, 1);
    chk_rd("ch2.sat", 8'd255, 8'd255, 8'd0, 8'd0, 2'd0);
    check("ch2.overflow", CW'(overflow), 8'b0000_0100);

    // Freeze while ch0 is mid-transaction; later activity must be ignored.
    rd_sel = 3'd0;
    cyc(0, 1, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 1);
    finish = 1'b1;
    cyc(0, 0, 0, 0, 1);
    finish = 1'b0;
    check("freeze.frozen", CW'(frozen), 8'd1);
    cyc(0, 1, 1, 1, 1);
    ctrl.ap_start[1] = 1'b1;
    ctrl.ap_ready[1] = 1'b1;
    for (int i = 0; i < 50; i++) cyc(0, i % 2, 1, (i / 2) % 2, 1);
    ctrl.ap_start[1] = 1'b0;
    ctrl.ap_ready[1] = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk_rd("frz.ch0", 8'd2, 8'd1, 8'd5, 8'd5, 2'd1);
    rd_sel = 3'd1;
    cyc(0, 0, 0, 0, 1);
    chk_rd("frz.ch1", 8'd2, 8'd1, 8'd3, 8'd3, 2'd0);
    check("frz.frozen_hold", CW'(frozen),   8'd1);
    check("frz.overflow",    CW'(overflow), 8'b0000_0100);

    // Asynchronous reset between edges clears everything at once.
    #2;
    reset = 1'b1;
    #1;
    chk_rd("rst2", 8'd0, 8'd0, 8'd0, 8'd0, 2'd0);
    check("rst2.frozen",   CW'(frozen),   8'd0);
    check("rst2.overflow", CW'(overflow), 8'd0);
    @(negedge clock);
    reset  = 1'b0;
    rd_sel = 3'd0;

    // Fresh measurement after reset: latency 3.
    cyc(0, 1, 1, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_rd("post_rst.ch0", 8'd1, 8'd1, 8'd3, 8'd3, 2'd0);

    // Out-of-range selects read as zero.
    rd_sel = 3'd5;
    @(negedge clock);
    chk_rd("sel5", 8'd0, 8'd0, 8'd0, 8'd0, 2'd0);
    rd_sel = 3'd7;
    @(negedge clock);
    check("sel7.start_cnt", rd_start_cnt, 8'd0);

    // Select switching takes effect exactly one edge later.
    cyc(1, 1, 1, 1, 1);
    cyc(1, 0, 0, 0, 1);
    rd_sel = 3'd0;
    @(negedge clock);
    check("sw.sel0_last", rd_last_lat, 8'd3);
    rd_sel = 3'd1;
    #1;
    check("sw.before_edge", rd_last_lat, 8'd3);
    @(negedge clock);
    chk_rd("sw.sel1", 8'd1, 8'd1, 8'd0, 8'd0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ap_channel_monitor.md
AP_CHANNEL_MONITOR -- requirements
Module: ap_channel_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored ap_ctrl channels (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of every statistics counter (legal 8..64).
REQ-003 SHALL have derived localparam SEL_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port ap_start  in  NUM_CH  per-channel start strobe.
REQ-007 SHALL have port ap_ready  in  NUM_CH  per-channel ready (start accepted).
REQ-008 SHALL have port ap_done  in  NUM_CH  per-channel done.
REQ-009 SHALL have port ap_continue  in  NUM_CH  per-channel continue; tie high for no-continue modules.
REQ-010 SHALL have port finish  in  1  end-of-test; freezes statistics.
REQ-011 SHALL have port rd_sel  in  SEL_W  channel index for readout.
REQ-012 SHALL have outputs rd_start_cnt, rd_done_cnt, rd_last_lat, rd_max_lat, each CNT_W: accepted starts, completed transactions, last latency, maximum latency of selected channel.
REQ-013 SHALL have output rd_state  out  2  FSM state of selected channel.
REQ-014 SHALL have outputs frozen  out  1 and overflow  out  NUM_CH (sticky per-channel saturation flag).

Function
REQ-015 Each channel SHALL run FSM IDLE(0), RUN(1), DONE_WAIT(2).
REQ-016 IDLE->RUN when ap_start=1 and ap_done=0; latency counter loads 1.
REQ-017 In RUN latency counter SHALL increment each cycle ap_done=0.
REQ-018 ap_done=1 in RUN SHALL set last_lat = latency counter value (start at cycle t, done at t+L gives L), increment done_cnt, update max_lat if last_lat > max_lat.
REQ-019 On that done cycle: ap_continue=1 -> IDLE; ap_continue=0 -> DONE_WAIT.
REQ-020 DONE_WAIT->IDLE on first cycle ap_continue=1; ap_start during DONE_WAIT SHALL NOT start latency counting.
REQ-021 ap_start and ap_done together in IDLE SHALL record last_lat=0, count one done, and follow REQ-019 continue rule.
REQ-022 start_cnt SHALL increment on every cycle ap_start=1 and ap_ready=1, in any state (pipelined re-starts counted; latency tracks the oldest transaction only).
REQ-023 Counters SHALL saturate at all-ones; any saturation sets overflow[ch], cleared only by reset.
REQ-024 finish=1 sampled SHALL set frozen=1; while frozen, counters, latencies and FSMs SHALL hold.
REQ-025 Readout outputs SHALL be registered: value for rd_sel sampled at cycle n appears at cycle n+1.
REQ-026 rd_sel >= NUM_CH SHALL return all-zero readout.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels each recorded same cycle.

Reset
REQ-028 Reset SHALL force every FSM to IDLE, all counters, latencies, readout outputs, overflow and frozen to 0, immediately and asynchronously.
REQ-029 Reset mid-transaction SHALL discard the partial latency; first post-reset start begins a fresh measurement.

Structure
REQ-030 Package ap_mon_pkg SHALL hold the channel-state enum and a per-channel statistics struct type parameterised by CNT_W via localparam default.
REQ-031 Per-channel FSM and counters SHALL live in sub-module ap_channel_tracker, instantiated NUM_CH times via generate; top holds freeze logic and readout mux.

Verification
REQ-032 Ch0: start cycle 10, ready cycle 10, done cycle 15, continue=1 -> start_cnt=1, done_cnt=1, last_lat=5, max_lat=5, state IDLE at cycle 16.
REQ-033 Ch1: done cycle 20 with continue=0 until cycle 24 -> state DONE_WAIT cycles 21-24, IDLE cycle 25; start at cycle 22 counted by start_cnt only.
REQ-034 Ch2 CNT_W=8: 300 handshakes -> start_cnt=255, overflow[2]=1, other channels' overflow=0.
REQ-035 Ch3 start+done same cycle -> last_lat=0, done_cnt=1; then latencies 7 then 3 -> last_lat=3, max_lat=7.
REQ-036 finish at cycle 50 during RUN on ch0 -> frozen=1 from cycle 51, counters unchanged through cycle 100; reset at cycle 101 -> all readouts 0 and frozen=0.
REQ-037 rd_sel=NUM_CH -> readouts 0 next cycle; rd_sel switching 0->1 updates data exactly one cycle later.
